// File: rtl/mcyc_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, pc_src selects,
// opcode/funct constants and the one-hot instruction class record.
package mcyc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] PC_SRC_PC4 = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;
    localparam logic [1:0] PC_SRC_RS  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mcyc_seq_ctrl_op_classify.sv
// Combinational op/funct to one-hot instruction class map, shared by the
// sequencer and the datapath decoder.
module mcyc_op_classify
    import mcyc_seq_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                // jr and jalr hide inside the R-type space; every other funct is ALU work
                case (funct)
                    FUNCT_JR:   cls.jr    = 1'b1;
                    FUNCT_JALR: cls.jalr  = 1'b1;
                    default:    cls.alu_r = 1'b1;
                endcase
            end
            OP_J:   cls.j   = 1'b1;
            OP_JAL: cls.jal = 1'b1;
            OP_BEQ: cls.beq = 1'b1;
            OP_BNE: cls.bne = 1'b1;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:  cls.alu_i = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:        cls.load  = 1'b1;
            OP_SB, OP_SH, OP_SW:                        cls.store = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcyc_seq_ctrl.sv
// Multi-cycle sequencer driving one shared req/ack memory port with a watchdog.
// Define MCYC_PERF_EN to add the cyc_cnt/ret_cnt performance counters.
module mcyc_seq_ctrl
    import mcyc_seq_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
`ifdef MCYC_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       run,
    input  logic [5:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       link,
    output logic       retire,
    output logic [2:0] state,
    output logic       fault
`ifdef MCYC_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    // Last wait count at which an ack is still accepted; one more miss is a fault.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 2);

    state_t    cur_state;
    state_t    nxt_state;
    logic [7:0] wait_cnt;
    op_class_t cls;
    logic      timeout;

    mcyc_op_classify u_classify (
        .op    (instr_op),
        .funct (instr_funct),
        .cls   (cls)
    );

    assign state   = cur_state;
    assign fault   = (cur_state == ST_FAULT);
    assign timeout = (wait_cnt == WAIT_LAST) && !mem_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= ST_IDLE;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if (mem_req && !mem_ack)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PC4;
        reg_we    = 1'b0;
        link      = 1'b0;
        retire    = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (run)
                    nxt_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    nxt_state = ST_DECODE;
                end else if (timeout) begin
                    nxt_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (cls.illegal) begin
                    nxt_state = ST_FAULT;
                end else if (cls.j) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JMP;
                    retire = 1'b1;
                end else if (cls.jal) begin
                    nxt_state = ST_WB;
                end else begin
                    nxt_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.beq) begin
                    pc_we  = zero;
                    pc_src = PC_SRC_BR;
                    retire = 1'b1;
                end else if (cls.bne) begin
                    pc_we  = !zero;
                    pc_src = PC_SRC_BR;
                    retire = 1'b1;
                end else if (cls.jr) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                    retire = 1'b1;
                end else if (cls.load || cls.store) begin
                    nxt_state = ST_MEM;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = cls.store;
                if (mem_ack) begin
                    if (cls.store)
                        retire = 1'b1;
                    else
                        nxt_state = ST_WB;
                end else if (timeout) begin
                    nxt_state = ST_FAULT;
                end
            end
            ST_WB: begin
                // The register file captures the pre-edge PC (already PC+4) on the link path.
                reg_we = 1'b1;
                retire = 1'b1;
                if (cls.jal) begin
                    link   = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JMP;
                end else if (cls.jalr) begin
                    link   = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
            end
            ST_FAULT: begin
                nxt_state = ST_FAULT;
            end
            default: begin
                nxt_state = ST_FAULT;
            end
        endcase
        if (retire)
            nxt_state = run ? ST_FETCH : ST_IDLE;
    end

`ifdef MCYC_PERF_EN
    // Counters see only working cycles, so they hold their value once parked in FAULT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (cur_state != ST_IDLE && cur_state != ST_FAULT)
                cyc_cnt <= cyc_cnt + 1'b1;
            if (retire)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif

endmodule
